// File: rtl/memory_access_stage_pkg.sv
// memory_access_stage_pkg: shared widths, control enums and FSM/holding types for the memory stage
package memory_access_stage_pkg;
    localparam int WORD       = 32;
    localparam int ADDR_WIDTH = 4;
    typedef enum logic [1:0] {FROM_ALU, FROM_MEMORY, FROM_PC} reg_file_data_source;
    typedef enum logic {WRITE_DISABLE, WRITE_ENABLE} reg_file_write_sig;
    typedef enum logic {NO_BRANCH, TAKE_BRANCH} branch_from_wb;
    typedef enum logic {IDLE, WAIT_ACK} mem_stage_state;
    typedef struct packed {
        logic                    valid;
        logic                    we;
        logic [WORD-1:0]         addr;
        logic [WORD-1:0]         wdata;
        reg_file_data_source     ctrl;
        reg_file_write_sig       wen;
        branch_from_wb           br;
        logic [ADDR_WIDTH-1:0]   dest;
    } mem_hold_t;
endpackage

// File: rtl/memory_access_stage_wb_reg.sv
// mem_wb_pipe_reg: write-back boundary registers; bubble_i forces an invalid slot
// Ports: clk_i/rst_i clock and sync reset; *_i next values; bubble_i kills valid; *_o registered outputs
module mem_wb_pipe_reg
    import memory_access_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bubble_i,
    input  logic                  valid_i,
    input  reg_file_data_source   ctrl_i,
    input  reg_file_write_sig     wen_i,
    input  branch_from_wb         br_i,
    input  logic [ADDR_WIDTH-1:0] dest_i,
    input  logic [WORD-1:0]       alu_i,
    input  logic [WORD-1:0]       mem_i,
    output logic                  valid_o,
    output reg_file_data_source   ctrl_o,
    output reg_file_write_sig     wen_o,
    output branch_from_wb         br_o,
    output logic [ADDR_WIDTH-1:0] dest_o,
    output logic [WORD-1:0]       alu_o,
    output logic [WORD-1:0]       mem_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= reg_file_data_source'(0);
            wen_o   <= reg_file_write_sig'(0);
            br_o    <= branch_from_wb'(0);
            dest_o  <= '0;
            alu_o   <= '0;
            mem_o   <= '0;
        end else begin
            valid_o <= valid_i & !bubble_i;
            ctrl_o  <= ctrl_i;
            wen_o   <= wen_i;
            br_o    <= br_i;
            dest_o  <= dest_i;
            alu_o   <= alu_i;
            mem_o   <= mem_i;
        end
    end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: performs loads/stores over a req/ack data port and registers results for write-back
// Ports: clk_i/rst_i clock and sync reset; execute-stage inputs (*_i); dmem_* memory handshake;
//        stall_o holds upstream; is_valid_o..mem_data_o registered write-back outputs
module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  is_valid_i,
    input  logic                  flush_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [WORD-1:0]       alu_result_i,
    input  logic [WORD-1:0]       store_data_i,
    input  reg_file_data_source   reg_data_ctrl_sig_i,
    input  reg_file_write_sig     reg_file_write_en_i,
    input  branch_from_wb         branch_from_wb_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic                  dmem_ack_i,
    input  logic [WORD-1:0]       dmem_rdata_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [WORD-1:0]       dmem_addr_o,
    output logic [WORD-1:0]       dmem_wdata_o,
    output logic                  stall_o,
    output logic                  is_valid_o,
    output reg_file_data_source   reg_data_ctrl_sig_o,
    output reg_file_write_sig     reg_file_write_en_o,
    output branch_from_wb         branch_from_wb_o,
    output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
    output logic [WORD-1:0]       alu_result_o,
    output logic [WORD-1:0]       mem_data_o
);
    mem_stage_state        state_q, state_d;
    mem_hold_t             hold_q, hold_d;
    logic                  mem_op, wb_valid, wb_bubble;
    reg_file_data_source   wb_ctrl;
    reg_file_write_sig     wb_wen;
    branch_from_wb         wb_br;
    logic [ADDR_WIDTH-1:0] wb_dest;
    logic [WORD-1:0]       wb_alu, wb_mem;

    assign mem_op       = is_valid_i & (mem_read_i | mem_write_i) & !flush_i;
    assign dmem_req_o   = state_q == WAIT_ACK;
    assign dmem_we_o    = dmem_req_o & hold_q.we;
    assign dmem_addr_o  = hold_q.addr;
    assign dmem_wdata_o = hold_q.wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stall_o   = 1'b0;
        wb_bubble = 1'b0;
        wb_valid  = is_valid_i & !flush_i;
        wb_ctrl   = reg_data_ctrl_sig_i;
        wb_wen    = reg_file_write_en_i;
        wb_br     = branch_from_wb_i;
        wb_dest   = reg_dest_addr_i;
        wb_alu    = alu_result_i;
        wb_mem    = '0;
        if (state_q == IDLE) begin
            if (mem_op) begin
                // a write flag wins when both read and write are set
                hold_d    = '{valid: 1'b1, we: mem_write_i, addr: alu_result_i, wdata: store_data_i,
                              ctrl: reg_data_ctrl_sig_i, wen: reg_file_write_en_i,
                              br: branch_from_wb_i, dest: reg_dest_addr_i};
                state_d   = WAIT_ACK;
                stall_o   = 1'b1;
                wb_bubble = 1'b1;
            end
        end else begin
            // a flush cannot cancel the bus request, so it only poisons the held valid
            hold_d.valid = hold_q.valid & !flush_i;
            wb_valid     = hold_d.valid;
            wb_ctrl      = hold_q.ctrl;
            wb_wen       = hold_q.wen;
            wb_br        = hold_q.br;
            wb_dest      = hold_q.dest;
            wb_alu       = hold_q.addr;
            wb_mem       = hold_q.we ? '0 : dmem_rdata_i;
            wb_bubble    = !dmem_ack_i;
            stall_o      = !dmem_ack_i;
            if (dmem_ack_i) state_d = IDLE;
        end
    end

    mem_wb_pipe_reg u_wb_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bubble_i (wb_bubble),
        .valid_i  (wb_valid),
        .ctrl_i   (wb_ctrl),
        .wen_i    (wb_wen),
        .br_i     (wb_br),
        .dest_i   (wb_dest),
        .alu_i    (wb_alu),
        .mem_i    (wb_mem),
        .valid_o  (is_valid_o),
        .ctrl_o   (reg_data_ctrl_sig_o),
        .wen_o    (reg_file_write_en_o),
        .br_o     (branch_from_wb_o),
        .dest_o   (reg_dest_addr_o),
        .alu_o    (alu_result_o),
        .mem_o    (mem_data_o)
    );
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed and random checks of the memory stage against transaction-level expectations
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic                  clk = 1'b0, rst = 1'b1;
    logic                  is_valid_i = 1'b0, flush_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [WORD-1:0]       alu_result_i = '0, store_data_i = '0, dmem_rdata_i = '0;
    reg_file_data_source   reg_data_ctrl_sig_i = FROM_ALU;
    reg_file_write_sig     reg_file_write_en_i = WRITE_DISABLE;
    branch_from_wb         branch_from_wb_i = NO_BRANCH;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_i = '0;
    logic                  dmem_ack_i = 1'b0;
    logic                  dmem_req_o, dmem_we_o, stall_o, is_valid_o;
    logic [WORD-1:0]       dmem_addr_o, dmem_wdata_o, alu_result_o, mem_data_o;
    reg_file_data_source   reg_data_ctrl_sig_o;
    reg_file_write_sig     reg_file_write_en_o;
    branch_from_wb         branch_from_wb_o;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_o;
    int checks = 0, failures = 0;

    memory_access_stage dut (
        .clk_i(clk), .rst_i(rst), .is_valid_i(is_valid_i), .flush_i(flush_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i), .reg_data_ctrl_sig_i(reg_data_ctrl_sig_i),
        .reg_file_write_en_i(reg_file_write_en_i), .branch_from_wb_i(branch_from_wb_i),
        .reg_dest_addr_i(reg_dest_addr_i), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .stall_o(stall_o), .is_valid_o(is_valid_o),
        .reg_data_ctrl_sig_o(reg_data_ctrl_sig_o), .reg_file_write_en_o(reg_file_write_en_o),
        .branch_from_wb_o(branch_from_wb_o), .reg_dest_addr_o(reg_dest_addr_o),
        .alu_result_o(alu_result_o), .mem_data_o(mem_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        is_valid_i          = 1'($urandom);
        mem_read_i          = 1'($urandom);
        mem_write_i         = 1'($urandom);
        alu_result_i        = $urandom;
        store_data_i        = $urandom;
        reg_data_ctrl_sig_i = reg_file_data_source'($urandom_range(0, 2));
        reg_file_write_en_i = reg_file_write_sig'($urandom_range(0, 1));
        branch_from_wb_i    = branch_from_wb'($urandom_range(0, 1));
        reg_dest_addr_i     = ADDR_WIDTH'($urandom);
    endtask

    // Single-cycle instruction that must not start a memory access.
    task automatic nm_op(input logic v, input logic f, input logic r, input logic w,
                         input logic [31:0] a, input reg_file_data_source c, input logic [3:0] d);
        reg_file_write_sig  en = reg_file_write_sig'($urandom_range(0, 1));
        branch_from_wb      b  = branch_from_wb'($urandom_range(0, 1));
        is_valid_i = v; flush_i = f; mem_read_i = r; mem_write_i = w; alu_result_i = a;
        store_data_i = $urandom; reg_data_ctrl_sig_i = c; reg_file_write_en_i = en;
        branch_from_wb_i = b; reg_dest_addr_i = d; dmem_ack_i = 1'($urandom); dmem_rdata_i = $urandom;
        #1;
        chk("nm_stall", 32'(stall_o), 32'd0);
        chk("nm_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        chk("nm_valid", 32'(is_valid_o), 32'(v & !f));
        chk("nm_alu", alu_result_o, a);
        chk("nm_dest", 32'(reg_dest_addr_o), 32'(d));
        chk("nm_ctrl", 32'(reg_data_ctrl_sig_o), 32'(c));
        chk("nm_wen", 32'(reg_file_write_en_o), 32'(en));
        chk("nm_br", 32'(branch_from_wb_o), 32'(b));
        chk("nm_mem", mem_data_o, 32'd0);
        @(negedge clk);
        flush_i = 1'b0; dmem_ack_i = 1'b0;
    endtask

    // Memory access acked in the n-th wait cycle; fa selects a wait cycle to pulse flush (out of range = none).
    task automatic mem_op(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input logic r, input logic w, input int n, input int fa,
                          input reg_file_data_source c);
        reg_file_write_sig     en = reg_file_write_sig'($urandom_range(0, 1));
        branch_from_wb         b  = branch_from_wb'($urandom_range(0, 1));
        logic [ADDR_WIDTH-1:0] d  = ADDR_WIDTH'($urandom);
        logic                  fl = 1'b0;
        is_valid_i = 1'b1; flush_i = 1'b0; mem_read_i = r; mem_write_i = w; alu_result_i = a;
        store_data_i = wd; reg_data_ctrl_sig_i = c; reg_file_write_en_i = en;
        branch_from_wb_i = b; reg_dest_addr_i = d; dmem_ack_i = 1'b0;
        #1;
        chk("issue_stall", 32'(stall_o), 32'd1);
        chk("issue_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        chk("issue_bubble", 32'(is_valid_o), 32'd0);
        @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            scramble();
            flush_i      = (k == fa);
            fl           = fl | flush_i;
            dmem_ack_i   = (k == n);
            dmem_rdata_i = (k == n) ? rd : $urandom;
            #1;
            chk("wait_req", 32'(dmem_req_o), 32'd1);
            chk("wait_we", 32'(dmem_we_o), 32'(w));
            chk("wait_addr", dmem_addr_o, a);
            chk("wait_wdata", dmem_wdata_o, wd);
            chk("wait_stall", 32'(stall_o), 32'(k != n));
            @(posedge clk); #1;
            if (k < n) chk("wait_bubble", 32'(is_valid_o), 32'd0);
            else begin
                chk("done_valid", 32'(is_valid_o), 32'(!fl));
                chk("done_alu", alu_result_o, a);
                chk("done_dest", 32'(reg_dest_addr_o), 32'(d));
                chk("done_ctrl", 32'(reg_data_ctrl_sig_o), 32'(c));
                chk("done_wen", 32'(reg_file_write_en_o), 32'(en));
                chk("done_br", 32'(branch_from_wb_o), 32'(b));
                chk("done_mem", mem_data_o, w ? 32'd0 : rd);
            end
            @(negedge clk);
        end
        flush_i = 1'b0; dmem_ack_i = 1'b0;
    endtask

    initial begin
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(is_valid_o), 32'd0);
        chk("rst_alu", alu_result_o, 32'd0);
        chk("rst_mem", mem_data_o, 32'd0);
        chk("rst_dest", 32'(reg_dest_addr_o), 32'd0);
        chk("rst_ctrl", 32'(reg_data_ctrl_sig_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        nm_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, FROM_ALU, 4'd3);
        mem_op(32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 3, 0, FROM_MEMORY);
        mem_op(32'h200, 32'hCAFE_F00D, 32'h1111_2222, 1'b0, 1'b1, 1, 0, FROM_ALU);
        mem_op(32'h300, 32'h0, 32'h5555_AAAA, 1'b1, 1'b0, 4, 2, FROM_MEMORY);
        mem_op(32'h400, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 2, 2, FROM_MEMORY);
        mem_op(32'hA0, 32'h0, 32'hAAAA_0001, 1'b1, 1'b0, 1, 0, FROM_MEMORY);
        mem_op(32'hB0, 32'h0, 32'hBBBB_0002, 1'b1, 1'b0, 1, 0, FROM_MEMORY);
        mem_op(32'h500, 32'h1234_5678, 32'h9999_9999, 1'b1, 1'b1, 2, 0, FROM_ALU);
        nm_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h600, FROM_MEMORY, 4'd7);
        nm_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h700, FROM_ALU, 4'd9);

        // reset in the middle of an outstanding load, then a late ack
        is_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; alu_result_i = 32'h800; flush_i = 1'b0;
        @(negedge clk);
        is_valid_i = 1'b0; dmem_ack_i = 1'b0;
        #1 chk("prerst_req", 32'(dmem_req_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req", 32'(dmem_req_o), 32'd0);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_valid", 32'(is_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("midrst_alu", alu_result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0; dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        #1;
        chk("lateack_req", 32'(dmem_req_o), 32'd0);
        chk("lateack_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("lateack_valid", 32'(is_valid_o), 32'd0);
        chk("lateack_mem", mem_data_o, 32'd0);
        @(negedge clk);
        dmem_ack_i = 1'b0;

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                int n = $urandom_range(1, 4);
                logic r = 1'($urandom), w = 1'($urandom);
                if (!r && !w) r = 1'b1;
                mem_op($urandom, $urandom, $urandom, r, w, n, $urandom_range(0, n + 3),
                       reg_file_data_source'($urandom_range(0, 2)));
            end else begin
                logic v = 1'($urandom), f = 1'($urandom), r = 1'($urandom), w = 1'($urandom);
                if (v && !f) begin r = 1'b0; w = 1'b0; end
                nm_op(v, f, r, w, $urandom, reg_file_data_source'($urandom_range(0, 2)), 4'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
